lisa_dmem_arbiter: RTL and testbench

- Shares one lisa data memory between two requesters: port 0 (core load/store unit) and port 1 (debug/DMA).
- Provides round-robin arbitration and valid/ready request handshakes.
- Performs byte/half/word loads with zero/sign extension; performs sub-word stores as single-cycle read-modify-write against the memory's combinational read.
- Sits between the requesters and the memory's write_en/addr/write_data/read_data pins.

---
 rtl/lisa_dmem_pkg.sv | 38 +++
 rtl/lisa_dmem_lane_merge.sv | 61 ++++++
 rtl/lisa_dmem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_lisa_dmem_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lisa_dmem_pkg.sv
// Shared encodings and types for the lisa data-memory arbiter.
package lisa_dmem_pkg;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned PORT_W = 1;

    localparam logic [SIZE_W-1:0] SZ_BYTE = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_HALF = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    // Request fields captured at acceptance.
    typedef struct packed {
        logic                we;
        logic [SIZE_W-1:0]   size;
        logic                sext;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [PORT_W-1:0]   port;
    } req_t;

    // Number of bytes touched by an access; illegal size reports a full word.
    function automatic logic [2:0] size_bytes(input logic [SIZE_W-1:0] size);
        case (size)
            SZ_BYTE: size_bytes = 3'd1;
            SZ_HALF: size_bytes = 3'd2;
            default: size_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lisa_dmem_lane_merge.sv
// Byte-lane handling for one access: store merge, load extract/extend, error check.
module lisa_dmem_lane_merge
    import lisa_dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic [SIZE_W-1:0] i_size,
    input  logic              i_sext,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [DATA_W-1:0] o_wdata_c,
    output logic [DATA_W-1:0] o_rdata_c,
    output logic              o_err_c
);

    logic [ADDR_W:0] w_end;
    logic            w_range_err;
    logic            w_align_err;

    // 17-bit end address so accesses near 0xFFFF cannot wrap into range.
    assign w_end       = {1'b0, i_addr} + (ADDR_W+1)'(size_bytes(i_size));
    assign w_range_err = w_end > (ADDR_W+1)'(MEM_BYTES);

    // Alignment and encoding errors.
    always_comb begin
        w_align_err = 1'b0;
        case (i_size)
            SZ_BYTE: w_align_err = 1'b0;
            SZ_HALF: w_align_err = i_addr[0];
            SZ_WORD: w_align_err = (i_addr[1:0] != 2'b00);
            default: w_align_err = 1'b1;
        endcase
    end

    assign o_err_c = w_align_err | w_range_err;

    // Merge store data into the current word and extract/extend load data.
    always_comb begin
        o_wdata_c = i_wdata;
        o_rdata_c = '0;
        case (i_size)
            SZ_BYTE: begin
                o_wdata_c = {i_rdata[31:8], i_wdata[7:0]};
                o_rdata_c = {{24{i_sext & i_rdata[7]}}, i_rdata[7:0]};
            end
            SZ_HALF: begin
                o_wdata_c = {i_rdata[31:16], i_wdata[15:0]};
                o_rdata_c = {{16{i_sext & i_rdata[15]}}, i_rdata[15:0]};
            end
            default: begin
                o_wdata_c = i_wdata;
                o_rdata_c = i_rdata;
            end
        endcase
        if (o_err_c) begin
            o_rdata_c = '0;
        end
    end

endmodule

// File: rtl/lisa_dmem_arbiter.sv
// Two-port round-robin arbiter in front of the lisa data memory.
module lisa_dmem_arbiter
    import lisa_dmem_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 1024
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [SIZE_W-1:0] p0_req_size,
    input  logic              p0_req_sext,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_rsp_valid,
    output logic              p0_rsp_err,
    output logic [DATA_W-1:0] p0_rsp_rdata,

    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [SIZE_W-1:0] p1_req_size,
    input  logic              p1_req_sext,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_rsp_valid,
    output logic              p1_rsp_err,
    output logic [DATA_W-1:0] p1_rsp_rdata,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [PORT_W-1:0] r_last_grant;
    req_t              r_req;
    req_t              w_sel_req;
    logic [ADDR_W-1:0] r_mem_addr;

    logic              w_can_accept;
    logic              w_grant0;
    logic              w_grant1;
    logic              w_accept;
    logic              w_in_access;

    logic [DATA_W-1:0] w_merge_wdata;
    logic [DATA_W-1:0] w_load_rdata;
    logic              w_err;

    logic              r_p0_rsp_valid;
    logic              r_p0_rsp_err;
    logic [DATA_W-1:0] r_p0_rsp_rdata;
    logic              r_p1_rsp_valid;
    logic              r_p1_rsp_err;
    logic [DATA_W-1:0] r_p1_rsp_rdata;

    assign w_in_access = (r_state == ST_ACCESS);

    // Grant selection, request mux and next-state logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_can_accept = (r_state != ST_ACCESS);
        w_grant0     = 1'b0;
        w_grant1     = 1'b0;
        w_sel_req    = '{we: p0_req_we, size: p0_req_size, sext: p0_req_sext,
                         addr: p0_req_addr, wdata: p0_req_wdata, port: PORT_W'(0)};

        if (p0_req_valid && (!p1_req_valid || r_last_grant == PORT_W'(1))) begin
            w_grant0 = 1'b1;
        end else if (p1_req_valid) begin
            w_grant1 = 1'b1;
            w_sel_req = '{we: p1_req_we, size: p1_req_size, sext: p1_req_sext,
                          addr: p1_req_addr, wdata: p1_req_wdata, port: PORT_W'(1)};
        end
        w_accept = w_can_accept & (w_grant0 | w_grant1);

        case (r_state)
            ST_IDLE, ST_RESP: w_state_nxt = w_accept ? ST_ACCESS : ST_IDLE;
            ST_ACCESS:        w_state_nxt = ST_RESP;
            default:          w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Latch the accepted request and rotate priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req        <= '0;
            r_last_grant <= PORT_W'(1);
            r_mem_addr   <= '0;
        end else if (w_accept) begin
            r_req        <= w_sel_req;
            r_last_grant <= w_sel_req.port;
            r_mem_addr   <= w_sel_req.addr;
        end
    end

    lisa_dmem_lane_merge #(
        .MEM_BYTES (MEM_BYTES)
    ) u_lane_merge (
        .i_size    (r_req.size),
        .i_sext    (r_req.sext),
        .i_addr    (r_req.addr),
        .i_wdata   (r_req.wdata),
        .i_rdata   (mem_rdata),
        .o_wdata_c (w_merge_wdata),
        .o_rdata_c (w_load_rdata),
        .o_err_c   (w_err)
    );

    // Capture the response at the end of ACCESS for the owning port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p0_rsp_valid <= 1'b0;
            r_p0_rsp_err   <= 1'b0;
            r_p0_rsp_rdata <= '0;
            r_p1_rsp_valid <= 1'b0;
            r_p1_rsp_err   <= 1'b0;
            r_p1_rsp_rdata <= '0;
        end else begin
            r_p0_rsp_valid <= w_in_access && (r_req.port == PORT_W'(0));
            r_p1_rsp_valid <= w_in_access && (r_req.port == PORT_W'(1));
            if (w_in_access && r_req.port == PORT_W'(0)) begin
                r_p0_rsp_err   <= w_err;
                r_p0_rsp_rdata <= r_req.we ? '0 : w_load_rdata;
            end
            if (w_in_access && r_req.port == PORT_W'(1)) begin
                r_p1_rsp_err   <= w_err;
                r_p1_rsp_rdata <= r_req.we ? '0 : w_load_rdata;
            end
        end
    end

    assign p0_req_ready = w_can_accept & w_grant0;
    assign p1_req_ready = w_can_accept & w_grant1;

    assign p0_rsp_valid = r_p0_rsp_valid;
    assign p0_rsp_err   = r_p0_rsp_err;
    assign p0_rsp_rdata = r_p0_rsp_rdata;
    assign p1_rsp_valid = r_p1_rsp_valid;
    assign p1_rsp_err   = r_p1_rsp_err;
    assign p1_rsp_rdata = r_p1_rsp_rdata;

    // Write strobe and merged data exist only during a legal store in ACCESS.
    assign mem_we    = w_in_access & r_req.we & ~w_err;
    assign mem_wdata = (w_in_access && r_req.we && !w_err) ? w_merge_wdata : '0;
    assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_lisa_dmem_arbiter.sv
// Self-checking bench: byte-array memory, behavioural model and directed/random stimulus.
module tb_lisa_dmem_arbiter;

    localparam int unsigned MEM_BYTES = 1024;
    localparam int MEM_SPAN = 65540;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  req_valid, req_ready, req_we, req_sext, rsp_valid, rsp_err;
    logic [1:0]  req_size [2];
    logic [15:0] req_addr [2];
    logic [31:0] req_wdata [2];
    logic [31:0] rsp_rdata [2];
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [7:0]  emem [0:MEM_SPAN-1];
    logic [7:0]  ref_mem [0:MEM_SPAN-1];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    typedef struct packed {
        logic        v;
        logic        port;
        logic        we_eff;
        logic [15:0] addr;
        logic [31:0] wword;
        logic        err;
        logic [31:0] rdata;
    } ev_t;

    ev_t  s_acc, s_rsp;
    logic m_prev_acc;
    logic m_last;

    lisa_dmem_arbiter #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(req_valid[0]), .p0_req_ready(req_ready[0]), .p0_req_we(req_we[0]),
        .p0_req_size(req_size[0]), .p0_req_sext(req_sext[0]), .p0_req_addr(req_addr[0]),
        .p0_req_wdata(req_wdata[0]), .p0_rsp_valid(rsp_valid[0]), .p0_rsp_err(rsp_err[0]),
        .p0_rsp_rdata(rsp_rdata[0]),
        .p1_req_valid(req_valid[1]), .p1_req_ready(req_ready[1]), .p1_req_we(req_we[1]),
        .p1_req_size(req_size[1]), .p1_req_sext(req_sext[1]), .p1_req_addr(req_addr[1]),
        .p1_req_wdata(req_wdata[1]), .p1_rsp_valid(rsp_valid[1]), .p1_rsp_err(rsp_err[1]),
        .p1_rsp_rdata(rsp_rdata[1]),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: combinational little-endian read, synchronous word write.
    assign mem_rdata = {emem[int'(mem_addr) + 3], emem[int'(mem_addr) + 2],
                        emem[int'(mem_addr) + 1], emem[int'(mem_addr)]};

    always @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) emem[int'(mem_addr) + i] <= mem_wdata[8*i +: 8];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic note_timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: no event within bound (cycle %0d)", name, cyc);
    endtask

    // Expected outcome of one request evaluated against the reference memory.
    function automatic ev_t model_eval(input logic port, input logic we, input logic [1:0] sz,
                                       input logic sx, input logic [15:0] a, input logic [31:0] wd);
        ev_t e;
        int nb;
        logic [31:0] word, val;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        e = '0;
        e.v = 1'b1;
        e.port = port;
        e.addr = a;
        e.err = (sz == 2'd3) || ((int'(a) % nb) != 0) || (int'(a) + nb > int'(MEM_BYTES));
        for (int i = 0; i < 4; i++) word[8*i +: 8] = ref_mem[int'(a) + i];
        val = '0;
        for (int i = 0; i < nb; i++) val[8*i +: 8] = word[8*i +: 8];
        if (nb < 4 && sx && val[8*nb-1]) begin
            for (int i = nb; i < 4; i++) val[8*i +: 8] = 8'hFF;
        end
        e.wword = word;
        for (int i = 0; i < nb; i++) e.wword[8*i +: 8] = wd[8*i +: 8];
        e.we_eff = we && !e.err;
        e.rdata = (we || e.err) ? 32'h0 : val;
        return e;
    endfunction

    // Compare process: predicts grants, memory strobes and responses every cycle.
    initial begin
        ev_t  nw;
        logic g0, g1;
        s_acc = '0;
        s_rsp = '0;
        m_prev_acc = 1'b0;
        m_last = 1'b1;
        forever begin
            @(posedge clk);
            if (rst_n && s_rsp.v && s_rsp.we_eff) begin
                for (int i = 0; i < 4; i++) ref_mem[int'(s_rsp.addr) + i] = s_rsp.wword[8*i +: 8];
            end
            @(negedge clk);
            if (!rst_n) begin
                s_acc = '0;
                s_rsp = '0;
                m_prev_acc = 1'b0;
                m_last = 1'b1;
                chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
                chk("rst_mem_we", 32'(mem_we), 32'h0);
                continue;
            end
            g0 = req_valid[0] && (!req_valid[1] || m_last) && !m_prev_acc;
            g1 = req_valid[1] && (!req_valid[0] || !m_last) && !m_prev_acc;
            chk("req_ready", 32'(req_ready), 32'({g1, g0}));
            chk("ready_exclusive", 32'(req_ready[0] & req_ready[1]), 32'h0);
            chk("mem_we", 32'(mem_we), 32'(s_acc.v && s_acc.we_eff));
            if (s_acc.v) chk("mem_addr", 32'(mem_addr), 32'(s_acc.addr));
            if (s_acc.v && s_acc.we_eff) chk("mem_wdata", mem_wdata, s_acc.wword);
            chk("rsp_valid", 32'(rsp_valid),
                s_rsp.v ? (s_rsp.port ? 32'h2 : 32'h1) : 32'h0);
            if (s_rsp.v) begin
                chk("rsp_err", 32'(rsp_err[s_rsp.port]), 32'(s_rsp.err));
                chk("rsp_rdata", rsp_rdata[s_rsp.port], s_rsp.rdata);
            end
            nw = '0;
            if (g0 || g1) begin
                nw = model_eval(g1, req_we[g1], req_size[g1], req_sext[g1],
                                req_addr[g1], req_wdata[g1]);
                m_last = g1;
            end
            m_prev_acc = g0 || g1;
            s_rsp = s_acc;
            s_acc = nw;
        end
    end

    task automatic set_req(input int p, input logic we, input logic [1:0] sz, input logic sx,
                           input logic [15:0] a, input logic [31:0] wd);
        req_valid[p] = 1'b1;
        req_we[p] = we;
        req_size[p] = sz;
        req_sext[p] = sx;
        req_addr[p] = a;
        req_wdata[p] = wd;
    endtask

    task automatic wait_accept(input int p, output int c);
        c = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready[p] && req_valid[p]) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) note_timeout("accept_timeout");
    endtask

    task automatic wait_rsp(input int p, output logic [31:0] rd, output logic er,
                            output int c, output logic we_first);
        c = -1;
        rd = 32'h0;
        er = 1'b0;
        we_first = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) we_first = mem_we;
            if (rsp_valid[p]) begin
                rd = rsp_rdata[p];
                er = rsp_err[p];
                c = cyc;
                break;
            end
        end
        if (c < 0) note_timeout("rsp_timeout");
    endtask

    task automatic do_req(input int p, input logic we, input logic [1:0] sz, input logic sx,
                          input logic [15:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output logic we_seen,
                          output int lat);
        int ca, cr;
        @(posedge clk);
        #1;
        set_req(p, we, sz, sx, a, wd);
        wait_accept(p, ca);
        @(posedge clk);
        #1;
        req_valid[p] = 1'b0;
        wait_rsp(p, rd, er, cr, we_seen);
        lat = cr - ca;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er, wes;
        int          lat, ca, cb, cr;
        int          cnt [2];
        int          seq [$];
        logic [31:0] w;

        for (int i = 0; i < MEM_SPAN; i++) begin
            emem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        req_valid = '0;
        req_we = '0;
        req_sext = '0;
        for (int p = 0; p < 2; p++) begin
            req_size[p] = 2'd0;
            req_addr[p] = 16'h0;
            req_wdata[p] = 32'h0;
        end

        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_mem_addr", 32'(mem_addr), 32'h0);
        chk("reset_mem_wdata", mem_wdata, 32'h0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Word store then load.
        do_req(0, 1'b1, 2'd2, 1'b0, 16'h0010, 32'hDEADBEEF, rd, er, wes, lat);
        chk("wstore_err", 32'(er), 32'h0);
        chk("wstore_we", 32'(wes), 32'h1);
        chk("wstore_latency", 32'(lat), 32'd2);
        chk("wstore_rdata", rd, 32'h0);
        do_req(0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd, er, wes, lat);
        chk("wload_rdata", rd, 32'hDEADBEEF);

        // Byte store merge and byte loads with/without sign extension.
        do_req(0, 1'b1, 2'd0, 1'b0, 16'h0011, 32'h123456A5, rd, er, wes, lat);
        do_req(0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0, rd, er, wes, lat);
        chk("bmerge_word", rd, 32'hDEADA5EF);
        do_req(0, 1'b0, 2'd0, 1'b1, 16'h0011, 32'h0, rd, er, wes, lat);
        chk("bload_sext", rd, 32'hFFFFFFA5);
        do_req(0, 1'b0, 2'd0, 1'b0, 16'h0011, 32'h0, rd, er, wes, lat);
        chk("bload_zext", rd, 32'h000000A5);

        // Error cases.
        do_req(0, 1'b1, 2'd1, 1'b0, 16'h0013, 32'h1111, rd, er, wes, lat);
        chk("half_misalign_err", 32'(er), 32'h1);
        chk("half_misalign_we", 32'(wes), 32'h0);
        do_req(1, 1'b0, 2'd2, 1'b0, 16'h03FC, 32'h0, rd, er, wes, lat);
        chk("last_word_err", 32'(er), 32'h0);
        do_req(1, 1'b0, 2'd2, 1'b0, 16'h0400, 32'h0, rd, er, wes, lat);
        chk("oob_word_err", 32'(er), 32'h1);
        chk("oob_word_rdata", rd, 32'h0);
        do_req(0, 1'b0, 2'd3, 1'b0, 16'h0010, 32'h0, rd, er, wes, lat);
        chk("size3_err", 32'(er), 32'h1);
        do_req(0, 1'b0, 2'd0, 1'b0, 16'hFFFF, 32'h0, rd, er, wes, lat);
        chk("wrap_addr_err", 32'(er), 32'h1);

        // Back-to-back on port 1: half store then half load, accepted two cycles apart.
        @(posedge clk);
        #1 set_req(1, 1'b1, 2'd1, 1'b0, 16'h0020, 32'h0000BEEF);
        wait_accept(1, ca);
        @(posedge clk);
        #1 set_req(1, 1'b0, 2'd1, 1'b0, 16'h0020, 32'h0);
        wait_accept(1, cb);
        chk("b2b_spacing", 32'(cb - ca), 32'd2);
        @(posedge clk);
        #1 req_valid[1] = 1'b0;
        wait_rsp(1, rd, er, cr, wes);
        chk("b2b_half_load", rd, 32'h0000BEEF);

        // Reset during ACCESS of a word store.
        @(posedge clk);
        #1 set_req(0, 1'b1, 2'd2, 1'b0, 16'h0030, 32'h12345678);
        wait_accept(0, ca);
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_midop_no_rsp", 32'(rsp_valid), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        w = {emem[16'h33], emem[16'h32], emem[16'h31], emem[16'h30]};
        chk("rst_midop_no_write", w, 32'h0);

        // Both ports contend for four requests each: grants alternate starting with port 0.
        cnt[0] = 0;
        cnt[1] = 0;
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 2'd2, 1'b0, 16'h0010, 32'h0);
        set_req(1, 1'b0, 2'd1, 1'b1, 16'h0020, 32'h0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            for (int p = 0; p < 2; p++) begin
                if (req_ready[p] && req_valid[p]) begin
                    seq.push_back(p);
                    cnt[p]++;
                end
            end
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) if (cnt[p] >= 4) req_valid[p] = 1'b0;
            if (cnt[0] >= 4 && cnt[1] >= 4) break;
        end
        chk("rr_count", 32'(seq.size()), 32'd8);
        for (int k = 0; k < seq.size(); k++) chk("rr_order", 32'(seq[k]), 32'(k % 2));
        repeat (3) @(posedge clk);

        // Randomised traffic on both ports.
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            for (int p = 0; p < 2; p++) begin
                int r;
                logic [15:0] a;
                r = int'($urandom_range(0, 99));
                if (r < 70) a = 16'($urandom_range(0, 63));
                else if (r < 85) a = 16'($urandom_range(16'h03F0, 16'h0403));
                else a = 16'($urandom_range(16'hFFF0, 16'hFFFF));
                req_valid[p] = ($urandom_range(0, 9) < 6);
                req_we[p] = $urandom_range(0, 1) == 1;
                req_size[p] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
                req_sext[p] = $urandom_range(0, 1) == 1;
                req_addr[p] = a;
                req_wdata[p] = $urandom;
            end
        end
        @(posedge clk);
        #1 req_valid = '0;
        repeat (4) @(posedge clk);

        // Memory contents must match the model after all traffic.
        for (int a = 0; a < 64; a += 4) begin
            chk("mem_final", {emem[a+3], emem[a+2], emem[a+1], emem[a]},
                {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]});
        end
        for (int a = 16'h03F0; a < 16'h0400; a += 4) begin
            chk("mem_final_top", {emem[a+3], emem[a+2], emem[a+1], emem[a]},
                {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
